q_table_updater: RTL and testbench
==================================

Name: q_table_updater

Overview:
- Write-side counterpart of action_determiner in the Q-learning accelerator. action_determiner reads Q-values and selects an action; this block consumes one (state, action, reward, next_state) transition and performs the Bellman update on the Q-table.
- Per transition it reads Q(s,a) and the four Q(next_state,*) entries, computes Q_new = Q + alpha*(r + gamma*max Q' - Q) with shift-based alpha/gamma, and writes Q_new back.
- It also provides the iteration counter and the registered Q_max consumed by action_determiner.

Parameters:
DATA_W, 32, signed Q-value/reward width (two's complement integer)
STATE_W, 4, state index width; Q-table address = {state, act}, STATE_W+2 bits
ALPHA_SHIFT, 1, alpha = 2^-ALPHA_SHIFT
GAMMA_SHIFT, 2, gamma*x = x - (x >>> GAMMA_SHIFT)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
upd_valid  in  1  transition offered
upd_ready  out  1  block can accept a transition
state  in  STATE_W  current state s
act  in  2  action taken a
next_state  in  STATE_W  resulting state s'
reward  in  DATA_W  signed reward r
rd_en  out  1  Q-table read strobe
rd_addr  out  STATE_W+2  read address
rd_data  in  DATA_W  read data, valid 1 cycle after rd_en
wr_en  out  1  Q-table write strobe (1 cycle)
wr_addr  out  STATE_W+2  write address
wr_data  out  DATA_W  updated Q-value
q_max  out  DATA_W  registered max Q(s',*) of last update
iteration  out  12  completed-update count
done  out  1  1-cycle pulse, coincident with wr_en

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; upd_ready=1; rd_en, wr_en, done=0; rd_addr, wr_addr, wr_data, q_max=0; iteration=0; internal registers cleared.
- Reset mid-operation aborts the update: no write is issued and iteration is unchanged.
- FSM states: IDLE, READ, WAIT, CALC, WRITE.
- IDLE: upd_ready=1. On upd_valid&&upd_ready, latch s, a, s' and r; go to READ. upd_ready=0 in all other states.
- Inputs are sampled only at the acceptance edge. Later input changes are ignored.
- READ: 5 consecutive cycles with rd_en=1, read index k=0..4.
  - k=0: rd_addr={s,a}.
  - k=1..4: rd_addr={s',k-1}.
  - Data for k is captured one cycle later: k=0 into q_cur; k=1..4 into a running signed max.
- WAIT: 1 cycle, rd_en=0, captures the k=4 data.
- CALC: 1 cycle. Compute at width DATA_W+3 with sign extension:
  - g = m - (m >>> GAMMA_SHIFT), where m is the max.
  - t = r + g.
  - d = t - q_cur.
  - n = q_cur + (d >>> ALPHA_SHIFT), arithmetic shift (floor toward -inf).
  - Saturate n to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register as wr_data.
  - q_max <= m.
- WRITE: wr_en=1, wr_addr={s,a}, done=1 for exactly one cycle. iteration increments, wrapping 4095->0. Next state is IDLE.
- Latency: wr_en is high in the 8th cycle after the acceptance edge. upd_ready rises the cycle after WRITE. Maximum throughput is one update per 9 cycles.
- Back-to-back: upd_valid held high is accepted on the first IDLE cycle. No request is lost or double-accepted.
- Self-loop (s=s'): all reads precede the write, so the max uses pre-update values. No forwarding is required.
- Max compare is signed. Ties do not affect the value.
- rd_addr, wr_addr and wr_data hold their last values when their strobes are low.

Test Plan:
- Common setup: ALPHA_SHIFT=1, GAMMA_SHIFT=2; the bench models a 1-cycle-latency RAM.
1. Q(3,1)=100; Q(5,*)=-50,-20,-10,0; r=-10; s=3, a=1, s'=5 -> max 0, t=-10, d=-110; wr_addr={3,1}, wr_data=45, q_max=0. wr_en is in cycle 8 after acceptance; done coincident; iteration=1.
2. Q(2,0)=0; Q(7,*)=50,-20,-10,0; r=0 -> g=50-12=38; wr_data=19, q_max=50.
3. Floor and negative values: Q(s,a)=0; Q(s',*)=-1 x4; r=-1 -> g=0, d=-1; wr_data=-1 (not 0).
4. Saturation: Q(s,a)=0x7FFFFFF0; Q(s',*)=0x7FFFFFFF; r=0x7FFFFFFF -> wr_data=0x7FFFFFFF. Mirror case with most-negative values -> wr_data=0x80000000.
5. Back-to-back and self-loop:
   - upd_valid held high for 3 transitions. upd_ready is low while busy; exactly 3 writes occur, spaced 9 cycles apart; iteration goes 1, 2, 3.
   - s=s'=2, a=1, Q(2,*)=0,40,0,0, r=0 -> max is the old value 40; wr_data = 40 + ((40-10-40)>>>1) = 35.
6. Reset: rst_n pulsed low during READ (3rd cycle after acceptance) -> no wr_en, iteration stays 0, all outputs 0, upd_ready=1 immediately. After release, a new transition completes normally. Also run iteration wrap: after 4096 updates iteration=0.

Source files
------------

// File: rtl/q_table_updater.sv
// Q-learning Bellman update engine: reads Q(s,a) and Q(s',*), computes the
// shift-based update with saturation, and writes the new value back.
module q_table_updater #(
  parameter int DATA_W      = 32,
  parameter int STATE_W     = 4,
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [STATE_W-1:0]   state,
  input  logic [1:0]           act,
  input  logic [STATE_W-1:0]   next_state,
  input  logic [DATA_W-1:0]    reward,
  output logic                 rd_en,
  output logic [STATE_W+1:0]   rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 wr_en,
  output logic [STATE_W+1:0]   wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    q_max,
  output logic [11:0]          iteration,
  output logic                 done
);

  // Handshake: a transition is taken on a rising edge where upd_valid && upd_ready;
  // upd_ready is high only in IDLE, and all inputs are captured on that edge only.

  localparam int EW = DATA_W + 3;

  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE} fsm_t;

  fsm_t                       fsm;
  logic [STATE_W-1:0]         s_r;
  logic [STATE_W-1:0]         ns_r;
  logic [1:0]                 a_r;
  logic signed [DATA_W-1:0]   r_r;
  logic signed [DATA_W-1:0]   q_cur;
  logic signed [DATA_W-1:0]   max_r;
  logic [2:0]                 rd_idx;

  logic signed [EW-1:0]       m_x;
  logic signed [EW-1:0]       r_x;
  logic signed [EW-1:0]       q_x;
  logic signed [EW-1:0]       g;
  logic signed [EW-1:0]       t;
  logic signed [EW-1:0]       d;
  logic signed [EW-1:0]       n;
  logic [EW-DATA_W:0]         hi;
  logic [DATA_W-1:0]          n_sat;

  // Extended width keeps r + gamma*max - q exact; overflow shows up in the top bits.
  always_comb begin
    m_x = {{3{max_r[DATA_W-1]}}, max_r};
    r_x = {{3{r_r[DATA_W-1]}}, r_r};
    q_x = {{3{q_cur[DATA_W-1]}}, q_cur};
    g   = m_x - (m_x >>> GAMMA_SHIFT);
    t   = r_x + g;
    d   = t - q_x;
    n   = q_x + (d >>> ALPHA_SHIFT);
    hi  = n[EW-1:DATA_W-1];
    if (hi == '0 || hi == '1) begin
      n_sat = n[DATA_W-1:0];
    end else if (n[EW-1]) begin
      n_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      n_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      upd_ready <= 1'b1;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      q_max     <= '0;
      iteration <= '0;
      s_r       <= '0;
      ns_r      <= '0;
      a_r       <= '0;
      r_r       <= '0;
      q_cur     <= '0;
      max_r     <= '0;
      rd_idx    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (upd_valid && upd_ready) begin
            s_r       <= state;
            a_r       <= act;
            ns_r      <= next_state;
            r_r       <= reward;
            rd_addr   <= {state, act};
            rd_en     <= 1'b1;
            rd_idx    <= 3'd0;
            upd_ready <= 1'b0;
            fsm       <= READ;
          end
        end
        READ: begin
          // rd_data now holds the word requested for index rd_idx-1
          if (rd_idx == 3'd1) begin
            q_cur <= rd_data;
          end else if (rd_idx == 3'd2 || (rd_idx > 3'd2 && $signed(rd_data) > max_r)) begin
            max_r <= rd_data;
          end
          if (rd_idx == 3'd4) begin
            rd_en <= 1'b0;
            fsm   <= WAIT;
          end else begin
            rd_idx  <= rd_idx + 3'd1;
            rd_addr <= {ns_r, rd_idx[1:0]};
          end
        end
        WAIT: begin
          if ($signed(rd_data) > max_r) max_r <= rd_data;
          fsm <= CALC;
        end
        CALC: begin
          wr_data <= n_sat;
          q_max   <= max_r;
          wr_addr <= {s_r, a_r};
          wr_en   <= 1'b1;
          done    <= 1'b1;
          fsm     <= WRITE;
        end
        WRITE: begin
          wr_en     <= 1'b0;
          done      <= 1'b0;
          iteration <= iteration + 12'd1;
          upd_ready <= 1'b1;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_table_updater.sv
// Bench for q_table_updater: 1-cycle RAM model, arithmetic Bellman reference,
// directed corner cases, random traffic, back-to-back, reset abort, counter wrap.
module tb_q_table_updater;

  localparam int AS = 1;
  localparam int GS = 2;

  typedef struct {
    logic [3:0]  s;
    logic [1:0]  a;
    logic [3:0]  ns;
    logic [31:0] r;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [3:0]  state = '0;
  logic [1:0]  act = '0;
  logic [3:0]  next_state = '0;
  logic [31:0] reward = '0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] q_max;
  logic [11:0] iteration;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [64];
  logic [31:0] qm [64];
  logic [31:0] exp_q[$];
  logic [11:0] exp_iter = '0;
  int          cyc = 0;
  int          wr_count = 0;
  int          wr_cyc = 0;
  int          upd_total = 0;

  q_table_updater #(.DATA_W(32), .STATE_W(4), .ALPHA_SHIFT(AS), .GAMMA_SHIFT(GS)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .state(state), .act(act), .next_state(next_state), .reward(reward),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_max(q_max), .iteration(iteration), .done(done)
  );

  // clock/reset block and RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_count <= wr_count + 1;
    end
  end

  // reference model
  function automatic longint floor_div(input longint x, input longint p);
    longint q;
    q = x / p;
    if ((x % p) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [31:0] max_next(input logic [3:0] ns);
    longint m;
    m = sx(qm[{ns, 2'd0}]);
    for (int k = 1; k < 4; k++) if (sx(qm[{ns, 2'(k)}]) > m) m = sx(qm[{ns, 2'(k)}]);
    return 32'(m);
  endfunction

  function automatic logic [31:0] bellman(input logic [31:0] qc, input logic [31:0] mx,
                                          input logic [31:0] r);
    longint g, d, n;
    logic [63:0] nb;
    g = sx(mx) - floor_div(sx(mx), longint'(2 ** GS));
    d = sx(r) + g - sx(qc);
    n = sx(qc) + floor_div(d, longint'(2 ** AS));
    if (n > 64'sd2147483647) n = 64'sd2147483647;
    if (n < -64'sd2147483648) n = -64'sd2147483648;
    nb = n;
    return nb[31:0];
  endfunction

  // driver tasks
  task automatic set_q(input logic [3:0] s, input logic [1:0] a, input logic [31:0] v);
    mem[{s, a}] = v;
    qm[{s, a}]  = v;
  endtask

  task automatic present(input txn_t t);
    state = t.s; act = t.a; next_state = t.ns; reward = t.r;
    upd_valid = 1'b1;
  endtask

  task automatic scramble();
    state = 4'($urandom); act = 2'($urandom);
    next_state = 4'($urandom); reward = $urandom;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.s = 4'($urandom); t.a = 2'($urandom); t.ns = 4'($urandom);
    t.r = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
    return t;
  endfunction

  // Caller presents t (upd_valid high) at a negedge; returns observed wr_data.
  task automatic xfer(input txn_t t, input bit hold, input txn_t nxt, output logic [31:0] got);
    logic [31:0] exp_m, exp_d;
    bit ok, busy_bad;
    int n;
    got = '0;
    exp_m = max_next(t.ns);
    exp_d = bellman(qm[{t.s, t.a}], exp_m, t.r);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (upd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: upd_ready=%b required 1", upd_ready);
      upd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) present(nxt);
    else begin upd_valid = 1'b0; scramble(); end
    exp_q.push_back(exp_d);
    busy_bad = 1'b0;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin n = c; break; end
      if (upd_ready !== 1'b0) busy_bad = 1'b1;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL write_latency: wr_en at cycle %0d required 8", n);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL ready_while_busy: upd_ready high during update, required 0");
    end
    if (n == 0) begin
      void'(exp_q.pop_front());
      return;
    end
    wr_cyc = cyc;
    exp_d = exp_q.pop_front();
    got = wr_data;
    checks++;
    if (wr_data !== exp_d) begin
      errors++;
      $display("FAIL wr_data: got %h required %h (s=%0d a=%0d ns=%0d r=%h)",
               wr_data, exp_d, t.s, t.a, t.ns, t.r);
    end
    checks++;
    if (wr_addr !== {t.s, t.a}) begin
      errors++;
      $display("FAIL wr_addr: got %h required %h", wr_addr, {t.s, t.a});
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_with_wr: got %b required 1", done);
    end
    checks++;
    if (q_max !== exp_m) begin
      errors++;
      $display("FAIL q_max: got %h required %h", q_max, exp_m);
    end
    qm[{t.s, t.a}] = exp_d;
    exp_iter = exp_iter + 12'd1;
    upd_total++;
    @(negedge clk);
    checks++;
    if (iteration !== exp_iter || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_write: iteration=%0d wr_en=%b done=%b required %0d 0 0",
               iteration, wr_en, done, exp_iter);
    end
  endtask

  task automatic one(input txn_t t, output logic [31:0] got);
    present(t);
    xfer(t, 1'b0, t, got);
  endtask

  // scenario tasks
  task automatic test_reset();
    checks++;
    if ({rd_en, wr_en, done, rd_addr, wr_addr, wr_data, q_max, iteration} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_en=%b wr_en=%b done=%b rd_addr=%h wr_addr=%h wr_data=%h q_max=%h iter=%0d required all 0",
               rd_en, wr_en, done, rd_addr, wr_addr, wr_data, q_max, iteration);
    end
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", upd_ready);
    end
  endtask

  task automatic test_reset_abort();
    txn_t t;
    logic [31:0] got;
    int w0;
    t = '{s: 4'd11, a: 2'd2, ns: 4'd12, r: 32'd77};
    present(t);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_abort: rd_en=%b required 1", rd_en);
    end
    w0 = wr_count;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, wr_en, done, rd_addr, wr_addr, wr_data, q_max, iteration} !== '0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: rd_en=%b wr_en=%b done=%b iter=%0d upd_ready=%b required 0 0 0 0 1",
               rd_en, wr_en, done, iteration, upd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_count != w0 || iteration !== 12'd0) begin
      errors++;
      $display("FAIL abort_no_write: writes=%0d iteration=%0d required 0 0", wr_count - w0, iteration);
    end
    exp_iter = '0;
    one(rand_txn(), got);
  endtask

  task automatic test_directed();
    logic [31:0] got;
    set_q(3, 1, 32'd100);
    set_q(5, 0, -32'sd50); set_q(5, 1, -32'sd20); set_q(5, 2, -32'sd10); set_q(5, 3, 32'd0);
    one('{s: 4'd3, a: 2'd1, ns: 4'd5, r: -32'sd10}, got);
    checks++;
    if (got !== 32'd45) begin errors++; $display("FAIL case_neg_max: got %0d required 45", $signed(got)); end

    set_q(2, 0, 32'd0);
    set_q(7, 0, 32'd50); set_q(7, 1, -32'sd20); set_q(7, 2, -32'sd10); set_q(7, 3, 32'd0);
    one('{s: 4'd2, a: 2'd0, ns: 4'd7, r: 32'd0}, got);
    checks++;
    if (got !== 32'd19) begin errors++; $display("FAIL case_gamma: got %0d required 19", $signed(got)); end

    set_q(8, 0, 32'd0);
    for (int k = 0; k < 4; k++) set_q(10, 2'(k), 32'hFFFF_FFFF);
    one('{s: 4'd8, a: 2'd0, ns: 4'd10, r: 32'hFFFF_FFFF}, got);
    checks++;
    if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL case_floor: got %h required ffffffff", got); end

    set_q(1, 2, 32'h7FFF_FFF0);
    for (int k = 0; k < 4; k++) set_q(4, 2'(k), 32'h7FFF_FFFF);
    one('{s: 4'd1, a: 2'd2, ns: 4'd4, r: 32'h7FFF_FFFF}, got);
    checks++;
    if (got !== 32'h7FFF_FFFF) begin errors++; $display("FAIL case_sat_pos: got %h required 7fffffff", got); end

    set_q(6, 3, 32'h8000_0010);
    for (int k = 0; k < 4; k++) set_q(9, 2'(k), 32'h8000_0000);
    one('{s: 4'd6, a: 2'd3, ns: 4'd9, r: 32'h8000_0000}, got);
    checks++;
    if (got !== 32'h8000_0000) begin errors++; $display("FAIL case_sat_neg: got %h required 80000000", got); end

    set_q(2, 0, 32'd0); set_q(2, 1, 32'd40); set_q(2, 2, 32'd0); set_q(2, 3, 32'd0);
    one('{s: 4'd2, a: 2'd1, ns: 4'd2, r: 32'd0}, got);
    checks++;
    if (got !== 32'd35) begin errors++; $display("FAIL case_self_loop: got %0d required 35", $signed(got)); end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int i = 0; i < 30; i++) one(rand_txn(), got);
  endtask

  task automatic test_back_to_back();
    txn_t t[3];
    logic [31:0] got;
    int w0, prev;
    for (int i = 0; i < 3; i++) t[i] = rand_txn();
    t[1].ns = t[0].s;
    w0 = wr_count;
    prev = 0;
    present(t[0]);
    for (int i = 0; i < 3; i++) begin
      xfer(t[i], i < 2, t[(i < 2) ? i + 1 : i], got);
      if (i > 0) begin
        checks++;
        if (wr_cyc - prev != 9) begin
          errors++;
          $display("FAIL b2b_spacing: write gap %0d cycles required 9", wr_cyc - prev);
        end
      end
      prev = wr_cyc;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_count - w0 != 3) begin
      errors++;
      $display("FAIL b2b_write_count: got %0d required 3", wr_count - w0);
    end
  endtask

  task automatic test_wrap();
    txn_t t, nxt;
    logic [31:0] got;
    t = rand_txn();
    present(t);
    while (upd_total < 4096) begin
      nxt = rand_txn();
      xfer(t, upd_total < 4095, nxt, got);
      t = nxt;
    end
    upd_valid = 1'b0;
    checks++;
    if (iteration !== 12'd0) begin
      errors++;
      $display("FAIL iteration_wrap: got %0d required 0", iteration);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'($signed(16'($urandom)));
      qm[i]  = mem[i];
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_reset_abort();
    test_directed();
    test_random();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
